opb_master_arb: RTL and testbench

- Two-requester OPB master arbiter.
- Sits between the OPB command sources (UART message parser on port M0, secondary host/debug parser on port M1) and the single OPB slave bus.
- Latches each requester's one-cycle RE/WE strobe and arbitrates round-robin between them. Issues one OPB transaction at a time, waits for the slave acknowledge with a timeout, and returns ack, read data and error to the owning requester.

---
 rtl/opb_master_arb.sv | 183 ++++++++++++++++++
 tb/tb_opb_master_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_master_arb.sv
// opb_master_arb
//   Two-requester OPB master arbiter. Each requester (M0: UART message parser,
//   M1: host/debug parser) issues one-cycle RE/WE strobes. These are latched
//   into a single-entry pending slot per requester. The arbiter picks one
//   request round-robin and issues it on the OPB bus. It then waits for
//   OPB_XFER_ACK, giving up after TIMEOUT_CYCLES. Completion (ack, read data,
//   error) is returned to the owning requester.
//
// Ports
//   OPB_CLK, OPB_RST           clock, synchronous active-high reset
//   Mx_RE / Mx_WE              requester read / write strobe (both = write)
//   Mx_ADDR / Mx_DO            requester address / write data, valid with strobe
//   Mx_BUSY                    requester has a pending or in-flight request
//   Mx_ACK / Mx_ERR            one-cycle completion pulse / timeout flag
//   Mx_DI                      read data returned to requester
//   OPB_ADDR / OPB_DO          bus address / write data (held until next grant)
//   OPB_RE / OPB_WE            one-cycle bus strobes
//   OPB_DI / OPB_XFER_ACK      slave read data / transfer acknowledge
//   TIMEOUT_CNT                saturating count of timed-out transactions
module opb_master_arb #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'h0000_0000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        M0_RE,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_DO,
  output logic        M0_BUSY,
  output logic        M0_ACK,
  output logic        M0_ERR,
  output logic [31:0] M0_DI,
  input  logic        M1_RE,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_DO,
  output logic        M1_BUSY,
  output logic        M1_ACK,
  output logic        M1_ERR,
  output logic [31:0] M1_DI,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  output logic        OPB_RE,
  output logic        OPB_WE,
  input  logic [31:0] OPB_DI,
  input  logic        OPB_XFER_ACK,
  output logic [7:0]  TIMEOUT_CNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_n;
  logic        pend0, pend1;
  logic        wr0, wr1;
  logic [31:0] addr0, addr1, do0, do1;
  logic        last_grant;
  logic        grant, grant_n;
  logic        cur_wr;
  logic [15:0] timer;
  logic        grant_now, go_resp, timed_out;
  logic        wr_sel;

  assign M0_BUSY = pend0;
  assign M1_BUSY = pend1;
  assign wr_sel  = grant_n ? wr1 : wr0;

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    grant_now = 1'b0;
    go_resp   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          grant_now = 1'b1;
          state_n   = ISSUE;
          if (pend0 && pend1) grant_n = ~last_grant;
          else                grant_n = pend1;
        end
      end
      ISSUE: begin
        if (OPB_XFER_ACK) begin
          state_n = RESP;
          go_resp = 1'b1;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (OPB_XFER_ACK) begin
          state_n = RESP;
          go_resp = 1'b1;
        end else if (timer == TIMEOUT_CYCLES - 16'd1) begin
          state_n   = RESP;
          go_resp   = 1'b1;
          timed_out = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      wr0         <= 1'b0;
      wr1         <= 1'b0;
      addr0       <= '0;
      addr1       <= '0;
      do0         <= '0;
      do1         <= '0;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cur_wr      <= 1'b0;
      timer       <= '0;
      OPB_RE      <= 1'b0;
      OPB_WE      <= 1'b0;
      OPB_ADDR    <= '0;
      OPB_DO      <= '0;
      M0_ACK      <= 1'b0;
      M0_ERR      <= 1'b0;
      M0_DI       <= '0;
      M1_ACK      <= 1'b0;
      M1_ERR      <= 1'b0;
      M1_DI       <= '0;
      TIMEOUT_CNT <= '0;
    end else begin
      // A strobe is only latched into an empty slot; the slot of the requester
      // being acknowledged stays full through RESP, so its strobe is dropped.
      if (!pend0 && (M0_RE || M0_WE)) begin
        pend0 <= 1'b1;
        addr0 <= M0_ADDR;
        do0   <= M0_DO;
        wr0   <= M0_WE;
      end
      if (!pend1 && (M1_RE || M1_WE)) begin
        pend1 <= 1'b1;
        addr1 <= M1_ADDR;
        do1   <= M1_DO;
        wr1   <= M1_WE;
      end
      if (state == RESP) begin
        last_grant <= grant;
        if (grant) pend1 <= 1'b0;
        else       pend0 <= 1'b0;
      end

      grant  <= grant_n;
      OPB_RE <= grant_now && !wr_sel;
      OPB_WE <= grant_now && wr_sel;
      if (grant_now) begin
        OPB_ADDR <= grant_n ? addr1 : addr0;
        OPB_DO   <= grant_n ? do1 : do0;
        cur_wr   <= wr_sel;
      end

      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 16'd1;

      // Completion is registered on the edge entering RESP so ACK/ERR/DI are
      // all visible together during the RESP cycle.
      M0_ACK <= go_resp && !grant;
      M1_ACK <= go_resp && grant;
      M0_ERR <= timed_out && !grant;
      M1_ERR <= timed_out && grant;
      if (go_resp && !cur_wr) begin
        if (grant) M1_DI <= timed_out ? TIMEOUT_DATA : OPB_DI;
        else       M0_DI <= timed_out ? TIMEOUT_DATA : OPB_DI;
      end
      if (timed_out && TIMEOUT_CNT != 8'hFF) TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_opb_master_arb.sv
module tb_opb_master_arb;

  localparam int          TO    = 16;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_re, m0_we, m1_re, m1_we;
  logic [31:0] m0_addr, m0_do, m1_addr, m1_do;
  logic        M0_BUSY, M0_ACK, M0_ERR, M1_BUSY, M1_ACK, M1_ERR;
  logic [31:0] M0_DI, M1_DI, OPB_ADDR, OPB_DO;
  logic        OPB_RE, OPB_WE;
  logic [31:0] opb_di;
  logic        opb_ack;
  logic [7:0]  TIMEOUT_CNT;

  opb_master_arb #(.TIMEOUT_CYCLES(16'd16), .TIMEOUT_DATA(TDATA)) dut (
    .OPB_CLK(clk), .OPB_RST(rst),
    .M0_RE(m0_re), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_DO(m0_do),
    .M0_BUSY(M0_BUSY), .M0_ACK(M0_ACK), .M0_ERR(M0_ERR), .M0_DI(M0_DI),
    .M1_RE(m1_re), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_DO(m1_do),
    .M1_BUSY(M1_BUSY), .M1_ACK(M1_ACK), .M1_ERR(M1_ERR), .M1_DI(M1_DI),
    .OPB_ADDR(OPB_ADDR), .OPB_DO(OPB_DO), .OPB_RE(OPB_RE), .OPB_WE(OPB_WE),
    .OPB_DI(opb_di), .OPB_XFER_ACK(opb_ack), .TIMEOUT_CNT(TIMEOUT_CNT)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;

  // Slave behaviour: >=0 ack that many cycles after the bus strobe,
  // -1 never ack, -2 random ack every cycle.
  int          ack_mode  = -1;
  logic [31:0] slave_data = 32'h0;
  logic        late_ack  = 1'b0;

  // Transaction-level reference: one pending slot per requester, and the
  // in-flight transaction described by owner plus issue/response cycle stamps.
  logic        m_pend [2];
  logic        m_wr   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] exp_di [2];
  int          m_owner = -1;
  int          m_issue = -1;
  int          m_resp  = -1;
  int          m_last  = 1;
  logic        m_cur_wr = 1'b0;
  logic        m_to     = 1'b0;
  logic [31:0] exp_oaddr, exp_odo;
  logic [7:0]  exp_cnt;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all;
    logic in_issue, in_resp;
    in_issue = (m_owner >= 0) && (cyc == m_issue);
    in_resp  = (m_owner >= 0) && (m_resp >= 0) && (cyc == m_resp);
    chk1("opb_re", OPB_RE, in_issue && !m_cur_wr);
    chk1("opb_we", OPB_WE, in_issue && m_cur_wr);
    chk32("opb_addr", OPB_ADDR, exp_oaddr);
    chk32("opb_do", OPB_DO, exp_odo);
    chk1("m0_busy", M0_BUSY, m_pend[0]);
    chk1("m1_busy", M1_BUSY, m_pend[1]);
    chk1("m0_ack", M0_ACK, in_resp && (m_owner == 0));
    chk1("m1_ack", M1_ACK, in_resp && (m_owner == 1));
    chk1("m0_err", M0_ERR, in_resp && (m_owner == 0) && m_to);
    chk1("m1_err", M1_ERR, in_resp && (m_owner == 1) && m_to);
    chk32("m0_di", M0_DI, exp_di[0]);
    chk32("m1_di", M1_DI, exp_di[1]);
    chk32("timeout_cnt", {24'h0, TIMEOUT_CNT}, {24'h0, exp_cnt});
  endtask

  task automatic model_step;
    logic op0, op1;
    int   w;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; exp_di[i] = '0;
      end
      m_owner = -1; m_issue = -1; m_resp = -1; m_last = 1;
      m_cur_wr = 1'b0; m_to = 1'b0; exp_oaddr = '0; exp_odo = '0; exp_cnt = '0;
    end else begin
      op0 = m_pend[0];
      op1 = m_pend[1];
      if (m_owner >= 0 && m_resp < 0) begin
        if (opb_ack) begin
          m_resp = cyc + 1;
          m_to   = 1'b0;
          if (!m_cur_wr) exp_di[m_owner] = opb_di;
        end else if (cyc == m_issue + TO) begin
          m_resp = cyc + 1;
          m_to   = 1'b1;
          if (!m_cur_wr) exp_di[m_owner] = TDATA;
          if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
      end else if (m_owner >= 0 && cyc == m_resp) begin
        m_pend[m_owner] = 1'b0;
        m_last  = m_owner;
        m_owner = -1;
      end else if (m_owner < 0 && (op0 || op1)) begin
        if (op0 && op1) w = 1 - m_last;
        else            w = op0 ? 0 : 1;
        m_owner   = w;
        m_issue   = cyc + 1;
        m_resp    = -1;
        m_cur_wr  = m_wr[w];
        exp_oaddr = m_addr[w];
        exp_odo   = m_data[w];
      end
      if (!op0 && (m0_re || m0_we)) begin
        m_pend[0] = 1'b1; m_addr[0] = m0_addr; m_data[0] = m0_do; m_wr[0] = m0_we;
      end
      if (!op1 && (m1_re || m1_we)) begin
        m_pend[1] = 1'b1; m_addr[1] = m1_addr; m_data[1] = m1_do; m_wr[1] = m1_we;
      end
    end
    cyc++;
  endtask

  task automatic drive_slave;
    opb_ack = 1'b0;
    opb_di  = $urandom;
    if (ack_mode >= 0) begin
      if (m_owner >= 0 && cyc == m_issue + ack_mode) begin
        opb_ack = 1'b1;
        opb_di  = slave_data;
      end
    end else if (ack_mode == -2) begin
      opb_ack = ($urandom_range(0, 2) == 0);
    end
    if (late_ack) opb_ack = 1'b1;
  endtask

  // Inputs for the current cycle are set by the caller before this is called.
  task automatic cycle;
    drive_slave();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
    m0_re = 1'b0; m0_we = 1'b0; m1_re = 1'b0; m1_we = 1'b0;
    late_ack = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int k;
    k = 0;
    while ((m_pend[0] || m_pend[1] || m_owner >= 0) && k < maxc) begin
      cycle();
      k++;
    end
    total++;
    assert (k < maxc) passed++;
    else begin
      failed++;
      $error("FAIL %s cyc=%0d observed=still_busy expected=idle_within_%0d", tag, cyc, maxc);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_re = 1'b0; m0_we = 1'b0; m1_re = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m0_do = '0; m1_addr = '0; m1_do = '0;
    opb_ack = 1'b0; opb_di = '0;
    @(posedge clk);
    model_step();
    #1;
    cycle();
    rst = 1'b0;
    run(3);

    // single read by M0, slave acks 3 cycles after OPB_RE
    ack_mode = 3; slave_data = 32'h1234_5678;
    m0_re = 1'b1; m0_addr = 32'h0000_0010; m0_do = $urandom;
    cycle();
    wait_done("single_read", 40);
    run(2);

    // single write by M1, ack in the ISSUE cycle
    ack_mode = 0; slave_data = 32'h5555_AAAA;
    m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_do = 32'hCAFE_F00D;
    cycle();
    wait_done("single_write", 40);
    run(2);

    // simultaneous M0 write / M1 read, repeated
    ack_mode = 1;
    for (int it = 0; it < 4; it++) begin
      slave_data = $urandom;
      m0_we = 1'b1; m0_addr = 32'h100 + it; m0_do = $urandom;
      m1_re = 1'b1; m1_addr = 32'h200 + it; m1_do = $urandom;
      cycle();
      wait_done("pair", 60);
      run(1);
    end

    // timeout, then a late ack while idle
    ack_mode = -1;
    m0_re = 1'b1; m0_addr = 32'h0000_0300;
    cycle();
    wait_done("timeout", 60);
    run(2);
    late_ack = 1'b1;
    cycle();
    run(3);

    // strobes while busy are dropped
    ack_mode = 2; slave_data = $urandom;
    m0_we = 1'b1; m0_addr = 32'h40; m0_do = 32'h1111_1111;
    cycle();
    m0_we = 1'b1; m0_addr = 32'h44; m0_do = 32'h2222_2222;
    cycle();
    m0_we = 1'b1; m0_addr = 32'h48; m0_do = 32'h3333_3333;
    cycle();
    wait_done("busy_drop", 40);
    run(2);

    // reset while waiting on the slave, then a fresh M1 read
    ack_mode = -1;
    m0_re = 1'b1; m0_addr = 32'h0000_0500;
    cycle();
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(1);
    ack_mode = 1; slave_data = 32'h0BAD_F00D;
    m1_re = 1'b1; m1_addr = 32'h0000_0080;
    cycle();
    wait_done("after_reset", 40);

    // randomized traffic, including a no-ack window and a mid-stream reset
    for (int i = 0; i < 500; i++) begin
      ack_mode = (i >= 200 && i < 280) ? -1 : -2;
      m0_addr = $urandom; m0_do = $urandom;
      m1_addr = $urandom; m1_do = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       m0_re = 1'b1;
          1:       m0_we = 1'b1;
          default: begin m0_re = 1'b1; m0_we = 1'b1; end
        endcase
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       m1_re = 1'b1;
          1:       m1_we = 1'b1;
          default: begin m1_re = 1'b1; m1_we = 1'b1; end
        endcase
      end
      if (i == 400) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end
    ack_mode = -2;
    wait_done("random_drain", 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
